// File: rtl/stopwatch_timer_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_timer_cu
//
// Second-generation stopwatch/timer control unit. Turns debounced button
// levels into run / clear / freeze / alarm controls for the time-counter
// datapath and the FND display controller.
//
// Each button is rising-edge detected internally, so a held button acts once.
// The edge-detect history registers reset to 1, so a button already held
// when reset is released does not produce an action.
//
// Optional feature: define STOPWATCH_LAP_EN to compile in the LAP (display
// freeze) state and lap-button edge detection. Without it, o_freeze is tied
// low, i_btn_lap is ignored and encoding 4 is an illegal state.
//
// Parameters:
//   ALARM_CYCLES  clk cycles o_alarm stays high in DONE (>= 2)
//   CNT_W         width of the alarm duration counter
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-low reset
//   i_btn_run     debounced run/stop button level
//   i_btn_clear   debounced clear button level
//   i_btn_mode    debounced mode button level
//   i_btn_lap     debounced lap button level (LAP builds only)
//   i_zero        datapath count == 0
//   o_run         datapath count enable
//   o_clear       datapath synchronous clear, one-cycle pulse
//   o_mode        0 = count up, 1 = count down
//   o_freeze      display holds last captured value
//   o_alarm       countdown finished indicator
//   o_state       current state encoding (debug/LED)
// -----------------------------------------------------------------------------
module stopwatch_timer_cu #(
  parameter int ALARM_CYCLES = 100_000_000,
  parameter int CNT_W        = $clog2(ALARM_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  input  logic       i_btn_lap,
  input  logic       i_zero,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_freeze,
  output logic       o_alarm,
  output logic [2:0] o_state
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DONE  = 3'd3,
    ST_LAP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DONE  = 3'd3
  } state_t;
`endif

  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] alarm_cnt;
  logic             prev_run, prev_clear, prev_mode;
  logic             run_edge, clear_edge, mode_edge;
  logic             mode_tgl;
  logic             zero_hit;

  assign run_edge   = i_btn_run   & ~prev_run;
  assign clear_edge = i_btn_clear & ~prev_clear;
  assign mode_edge  = i_btn_mode  & ~prev_mode;

  // Countdown completion only exists in down mode.
  assign zero_hit = o_mode & i_zero;

`ifdef STOPWATCH_LAP_EN
  logic prev_lap;
  logic lap_edge;

  assign lap_edge = i_btn_lap & ~prev_lap;

  always_ff @(posedge clk) begin
    if (!reset) prev_lap <= 1'b1;
    else        prev_lap <= i_btn_lap;
  end
`else
  logic unused_lap;
  assign unused_lap = i_btn_lap;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_STOP;
      o_mode     <= 1'b0;
      alarm_cnt  <= '0;
      prev_run   <= 1'b1;
      prev_clear <= 1'b1;
      prev_mode  <= 1'b1;
    end else begin
      state      <= state_nx;
      o_mode     <= o_mode ^ mode_tgl;
      prev_run   <= i_btn_run;
      prev_clear <= i_btn_clear;
      prev_mode  <= i_btn_mode;
      // Counter only advances while staying in DONE; any exit clears it.
      if (state == ST_DONE && state_nx == ST_DONE) alarm_cnt <= alarm_cnt + CNT_W'(1);
      else                                         alarm_cnt <= '0;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    mode_tgl = 1'b0;
    case (state)
      ST_STOP: begin
        // A run press in down mode at zero is ignored, not an action.
        if (run_edge && !zero_hit) state_nx = ST_RUN;
        else if (clear_edge)       state_nx = ST_CLEAR;
        else if (mode_edge)        mode_tgl = 1'b1;
      end
      ST_RUN: begin
        if (zero_hit)      state_nx = ST_DONE;
        else if (run_edge) state_nx = ST_STOP;
`ifdef STOPWATCH_LAP_EN
        else if (lap_edge) state_nx = ST_LAP;
`endif
      end
      ST_CLEAR: state_nx = ST_STOP;
      ST_DONE: begin
        if (clear_edge)                  state_nx = ST_CLEAR;
        else if (run_edge)               state_nx = ST_STOP;
        else if (alarm_cnt == ALARM_LAST) state_nx = ST_STOP;
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (zero_hit)      state_nx = ST_DONE;
        else if (run_edge) state_nx = ST_STOP;
        else if (lap_edge) state_nx = ST_RUN;
      end
`endif
      default: state_nx = ST_STOP;
    endcase
  end

  // Moore output decode.
  always_comb begin
    o_run    = 1'b0;
    o_clear  = 1'b0;
    o_freeze = 1'b0;
    o_alarm  = 1'b0;
    case (state)
      ST_RUN:   o_run   = 1'b1;
      ST_CLEAR: o_clear = 1'b1;
      ST_DONE:  o_alarm = 1'b1;
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        o_run    = 1'b1;
        o_freeze = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_stopwatch_timer_cu.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_timer_cu
//
// Directed testbench for stopwatch_timer_cu with ALARM_CYCLES = 8. Each
// observation packs {o_run, o_clear, o_mode, o_freeze, o_alarm, o_state}
// and compares it against a hand-computed expectation. Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_stopwatch_timer_cu;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run, btn_clear, btn_mode, btn_lap, zero;
  logic       o_run, o_clear, o_mode, o_freeze, o_alarm;
  logic [2:0] o_state;
  logic [7:0] obs, e;
  int         n_vec = 0;
  int         n_err = 0;

  stopwatch_timer_cu #(.ALARM_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_btn_run  (btn_run),
    .i_btn_clear(btn_clear),
    .i_btn_mode (btn_mode),
    .i_btn_lap  (btn_lap),
    .i_zero     (zero),
    .o_run      (o_run),
    .o_clear    (o_clear),
    .o_mode     (o_mode),
    .o_freeze   (o_freeze),
    .o_alarm    (o_alarm),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  assign obs = {o_run, o_clear, o_mode, o_freeze, o_alarm, o_state};

  // Expected packed observation {run, clear, mode, freeze, alarm, state}.
  function automatic logic [7:0] ev(input logic r, input logic c, input logic m,
                                    input logic f, input logic a, input logic [2:0] s);
    return {r, c, m, f, a, s};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic btn(input logic r, input logic c, input logic m, input logic l);
    btn_run = r; btn_clear = c; btn_mode = m; btn_lap = l;
  endtask

  task automatic test_reset;
    reset = 1'b0; zero = 1'b0; btn(1, 0, 0, 0);
    cyc(3);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL reset_state obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    reset = 1'b1;
    cyc(2);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL reset_held_run obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL reset_run_press obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    cyc(3);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL run_hold obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL run_stop obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
  endtask

  task automatic test_clear_hold;
    btn(0, 1, 0, 0); cyc(1);
    e = ev(0,1,0,0,0,2); if (obs !== e) begin $display("FAIL clear_pulse obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL clear_hold_%0d obs=%b exp=%b", i, obs, e); n_err++; end n_vec++;
    end
    btn(0, 0, 0, 0); cyc(1);
  endtask

  task automatic test_countdown_alarm;
    btn(0, 0, 1, 0); cyc(1);
    e = ev(0,0,1,0,0,0); if (obs !== e) begin $display("FAIL mode_toggle obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); zero = 1'b1; cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(0,0,1,0,0,0); if (obs !== e) begin $display("FAIL run_at_zero obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); zero = 1'b0; cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(1,0,1,0,0,1); if (obs !== e) begin $display("FAIL down_run obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); zero = 1'b1; cyc(1);
    e = ev(0,0,1,0,1,3); if (obs !== e) begin $display("FAIL done_entry obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    for (int i = 2; i <= 8; i++) begin
      cyc(1);
      e = ev(0,0,1,0,1,3); if (obs !== e) begin $display("FAIL alarm_cycle_%0d obs=%b exp=%b", i, obs, e); n_err++; end n_vec++;
    end
    cyc(1);
    e = ev(0,0,1,0,0,0); if (obs !== e) begin $display("FAIL alarm_end obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    zero = 1'b0; cyc(1);
  endtask

  task automatic test_done_early;
    btn(1, 0, 0, 0); cyc(1);
    btn(0, 0, 0, 0); zero = 1'b1; cyc(1);
    zero = 1'b0; cyc(2);
    e = ev(0,0,1,0,1,3); if (obs !== e) begin $display("FAIL done_cycle3 obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(1, 1, 0, 0); cyc(1);
    e = ev(0,1,1,0,0,2); if (obs !== e) begin $display("FAIL done_clear_prio obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    e = ev(0,0,1,0,0,0); if (obs !== e) begin $display("FAIL done_clear_stop obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    // Early exit by run, then a full alarm to confirm the counter restarted.
    btn(1, 0, 0, 0); cyc(1);
    btn(0, 0, 0, 0); zero = 1'b1; cyc(1);
    zero = 1'b0; cyc(2);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(0,0,1,0,0,0); if (obs !== e) begin $display("FAIL done_run_stop obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    btn(0, 0, 0, 0); zero = 1'b1; cyc(1);
    zero = 1'b0; cyc(7);
    e = ev(0,0,1,0,1,3); if (obs !== e) begin $display("FAIL realarm_cycle8 obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    cyc(1);
    e = ev(0,0,1,0,0,0); if (obs !== e) begin $display("FAIL realarm_end obs=%b exp=%b", obs, e); n_err++; end n_vec++;
  endtask

  task automatic test_mode_in_run;
    btn(0, 0, 1, 0); cyc(1);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL mode_back_up obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    btn(0, 0, 1, 0); cyc(1);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL mode_in_run obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); zero = 1'b1; cyc(2);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL up_zero_ignored obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 1, 0, 0); cyc(1);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL clear_in_run obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); zero = 1'b0; cyc(1);
  endtask

  task automatic test_lap;
`ifdef STOPWATCH_LAP_EN
    btn(0, 0, 0, 1); cyc(1);
    e = ev(1,0,0,1,0,4); if (obs !== e) begin $display("FAIL lap_enter obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    cyc(2);
    e = ev(1,0,0,1,0,4); if (obs !== e) begin $display("FAIL lap_hold obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(0, 0, 0, 1); cyc(1);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL lap_release obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(0, 0, 0, 1); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL lap_run_stop obs=%b exp=%b", obs, e); n_err++; end n_vec++;
`else
    btn(0, 0, 0, 1); cyc(1);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL lap_disabled obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL lap_disabled_stop obs=%b exp=%b", obs, e); n_err++; end n_vec++;
`endif
    btn(0, 0, 0, 0); cyc(1);
  endtask

  task automatic test_simultaneous;
    btn(1, 1, 1, 0); cyc(1);
    e = ev(1,0,0,0,0,1); if (obs !== e) begin $display("FAIL stop_all_edges obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    btn(0, 1, 1, 0); cyc(1);
    e = ev(0,1,0,0,0,2); if (obs !== e) begin $display("FAIL stop_clear_mode obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    btn(0, 0, 0, 0); cyc(1);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL simul_settle obs=%b exp=%b", obs, e); n_err++; end n_vec++;
  endtask

  task automatic test_reset_mid;
    btn(0, 0, 1, 0); cyc(1);
    btn(0, 0, 0, 0); cyc(1);
    btn(1, 0, 0, 0); cyc(1);
    btn(0, 0, 0, 0); zero = 1'b1; cyc(2);
    e = ev(0,0,1,0,1,3); if (obs !== e) begin $display("FAIL pre_reset_done obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    reset = 1'b0; cyc(1);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL reset_in_done obs=%b exp=%b", obs, e); n_err++; end n_vec++;
    reset = 1'b1; zero = 1'b0; cyc(2);
    e = ev(0,0,0,0,0,0); if (obs !== e) begin $display("FAIL post_reset obs=%b exp=%b", obs, e); n_err++; end n_vec++;
  endtask

  initial begin
    test_reset;
    test_clear_hold;
    test_countdown_alarm;
    test_done_early;
    test_mode_in_run;
    test_lap;
    test_simultaneous;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
